des_key_sched_dec: RTL and testbench

- Sequential DES key scheduler that produces the 16 round subkeys in decryption order, K16 first and K1 last.
- Feeds the decrypt datapath, which consumes one subkey per round.
- Loads a 64-bit key, applies PC-1, then right-rotates C/D with the decryption shift schedule and emits PC-2 of each C/D state.
- Also serves as the inverse-direction companion to the encrypt-side PC-2 compression.

---
 rtl/des_key_sched_dec.sv | 187 ++++++++++++++++++
 tb/tb_des_key_sched_dec.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_dec.sv
// Sequential DES key scheduler: emits the 16 round subkeys K16..K1, one per un-held cycle.
// Optional macro DES_KS_ENC_EN adds a mode input selecting encrypt order (K1..K16).
module des_key_sched_dec #(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] key,
`ifdef DES_KS_ENC_EN
    input  logic        mode,
`endif
    input  logic        hold,
    output logic        busy,
    output logic        subkey_valid,
    output logic [3:0]  round,
    output logic [47:0] subkey,
    output logic        done
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    // Table entries are 1-based MSB-first bit numbers; convert to vector indices.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [5:0] src;
        logic [5:0] dst;
        pc1 = '0;
        for (int i = 0; i < 56; i++) begin
            src = 6'(64 - PC1_TBL[i]);
            dst = 6'(55 - i);
            pc1[dst] = k[src];
        end
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [5:0] src;
        logic [5:0] dst;
        pc2 = '0;
        for (int i = 0; i < 48; i++) begin
            src = 6'(56 - PC2_TBL[i]);
            dst = 6'(47 - i);
            pc2[dst] = cd[src];
        end
    endfunction

    function automatic logic [27:0] rot(input logic [27:0] x, input logic [1:0] s,
                                        input logic left);
        logic [27:0] r;
        r = x;
        if (left) begin
            if (s == 2'd1)      r = {x[26:0], x[27]};
            else if (s == 2'd2) r = {x[25:0], x[27:26]};
        end else begin
            if (s == 2'd1)      r = {x[0], x[27:1]};
            else if (s == 2'd2) r = {x[1:0], x[27:2]};
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [63:0] key_q, key_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [3:0]  round_q, round_d;
    logic [47:0] subkey_q, subkey_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        enc;
    logic [1:0]  shift;
    logic [27:0] c_rot, d_rot;

`ifdef DES_KS_ENC_EN
    logic        mode_q, mode_d;
    assign enc = mode_q;
`else
    assign enc = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        c_d      = c_q;
        d_d      = d_q;
        rnd_d    = rnd_q;
        round_d  = round_q;
        subkey_d = subkey_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
`ifdef DES_KS_ENC_EN
        mode_d   = mode_q;
`endif
        // rnd_q holds r-1; decrypt starts with a zero shift so the first subkey is K16.
        if (enc)
            shift = (rnd_q == 4'd0 || rnd_q == 4'd1 || rnd_q == 4'd8 || rnd_q == 4'd15) ? 2'd1 : 2'd2;
        else if (rnd_q == 4'd0)
            shift = 2'd0;
        else
            shift = (rnd_q == 4'd1 || rnd_q == 4'd8 || rnd_q == 4'd15) ? 2'd1 : 2'd2;
        c_rot = rot(c_q, shift, enc);
        d_rot = rot(d_q, shift, enc);

        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key;
`ifdef DES_KS_ENC_EN
                    mode_d  = mode;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                {c_d, d_d} = pc1(key_q);
                rnd_d      = 4'd0;
                state_d    = RUN;
            end
            RUN: begin
                if (!hold) begin
                    c_d      = c_rot;
                    d_d      = d_rot;
                    subkey_d = pc2({c_rot, d_rot});
                    round_d  = rnd_q;
                    valid_d  = 1'b1;
                    rnd_d    = rnd_q + 4'd1;
                    if (rnd_q == LAST_RND) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            key_q    <= '0;
            c_q      <= '0;
            d_q      <= '0;
            rnd_q    <= '0;
            round_q  <= '0;
            subkey_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
`ifdef DES_KS_ENC_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            c_q      <= c_d;
            d_q      <= d_d;
            rnd_q    <= rnd_d;
            round_q  <= round_d;
            subkey_q <= subkey_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
`ifdef DES_KS_ENC_EN
            mode_q   <= mode_d;
`endif
        end
    end

    assign busy         = (state_q != IDLE);
    assign subkey_valid = valid_q;
    assign round        = round_q;
    assign subkey       = subkey_q;
    assign done         = done_q;

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Testbench for des_key_sched_dec: directed timing checks plus random keys scored
// against a table-driven FIPS 46-3 key schedule model.
module tb_des_key_sched_dec;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [63:0] key = '0;
    logic        hold = 1'b0;
    logic        busy;
    logic        subkey_valid;
    logic [3:0]  round;
    logic [47:0] subkey;
    logic        done;
`ifdef DES_KS_ENC_EN
    logic        mode = 1'b0;
`endif

    localparam logic [63:0] KEY0      = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1_KNOWN  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_KNOWN = 48'hCB3D8B0E17F5;

    int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4
    };
    int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32
    };
    int LSHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    logic [52:0] exp_q[$];
    logic [47:0] sched [16];
    int total = 0;
    int bad = 0;

    des_key_sched_dec dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .key(key),
`ifdef DES_KS_ENC_EN
        .mode(mode),
`endif
        .hold(hold),
        .busy(busy),
        .subkey_valid(subkey_valid),
        .round(round),
        .subkey(subkey),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Standard encrypt schedule: Kr = PC2(C0/D0 rotated left by the cumulative shift).
    // Result is stored in emission order (reversed for decrypt), then queued.
    task automatic model_push(input logic [63:0] k, input bit enc);
        logic [55:0] cd;
        logic [47:0] ks;
        int tot;
        int p;
        int src;
        cd = '0;
        for (int i = 0; i < 56; i++)
            cd = {cd[54:0], 1'((k >> (64 - PC1[i])) & 64'd1)};
        tot = 0;
        for (int r = 0; r < 16; r++) begin
            tot += LSHIFT[r];
            ks = '0;
            for (int j = 0; j < 48; j++) begin
                p = PC2[j];
                if (p <= 28) src = ((p - 1 + tot) % 28) + 1;
                else         src = 28 + ((p - 29 + tot) % 28) + 1;
                ks = {ks[46:0], 1'((cd >> (56 - src)) & 56'd1)};
            end
            if (enc) sched[r] = ks;
            else     sched[15 - r] = ks;
        end
        for (int r = 0; r < 16; r++)
            exp_q.push_back({4'(r), sched[r], (r == 15)});
    endtask

    task automatic drive_mode(input bit enc);
`ifdef DES_KS_ENC_EN
        mode = enc;
`else
        if (enc) $display("note: encrypt order needs DES_KS_ENC_EN");
`endif
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s actual=no_done required=done", name);
        end
    endtask

    // One job with cycle-exact checks. Cycle idx 0 is the cycle after the accepting edge.
    // do_hold stalls 3 cycles once round index 4 is out; poke pulses start at round 8;
    // chain starts a second job in the cycle done is visible.
    task automatic run_checked(input logic [63:0] k, input bit enc, input bit do_hold,
                               input bit poke, input bit chain, input logic [63:0] k_chain,
                               input logic [47:0] first_exp, input logic [47:0] last_exp);
        int g;
        logic [47:0] held;
        bit exp_v;
        g = do_hold ? 3 : 0;
        model_push(k, enc);
        held = sched[4];
        key = k;
        drive_mode(enc);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        key = ~k;
        drive_mode(!enc);
        for (int idx = 0; idx <= 18 + g; idx++) begin
            @(negedge clk);
            exp_v = (idx >= 2 && idx <= 6) || (idx >= 7 + g && idx <= 17 + g);
            check("valid_timing", 64'(subkey_valid), 64'(exp_v));
            check("busy_timing", 64'(busy), 64'((idx <= 16 + g) || (chain && idx == 18 + g)));
            check("done_timing", 64'(done), 64'(idx == 17 + g));
            if (idx == 2) check("first_subkey", 64'(subkey), 64'(first_exp));
            if (idx == 17 + g) check("last_subkey", 64'(subkey), 64'(last_exp));
            if (do_hold && idx >= 7 && idx <= 6 + g) begin
                check("hold_subkey", 64'(subkey), 64'(held));
                check("hold_round", 64'(round), 64'd4);
            end
            hold = do_hold && idx >= 6 && idx <= 5 + g;
            if (poke) begin
                start = (idx == 10);
                if (idx == 10) key = k ^ 64'h0F0F_0F0F_F0F0_F0F0;
            end
            if (chain && idx == 17 + g) begin
                key = k_chain;
                model_push(k_chain, enc);
                start = 1'b1;
            end
            if (chain && idx == 18 + g) start = 1'b0;
        end
        hold = 1'b0;
        start = 1'b0;
    endtask

    // Scoreboard monitor: every presented subkey must match the next queued expectation.
    initial begin
        logic [52:0] e;
        logic [52:0] a;
        forever begin
            @(negedge clk);
            if (rst && subkey_valid) begin
                a = {round, subkey, done};
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected actual=%0h required=none", a);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_round_subkey_done", 64'(a), 64'(e));
                end
            end
        end
    end

    initial begin
        bit seen;
        bit enc;
        logic [63:0] k;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(subkey_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_round", 64'(round), 64'd0);
        check("rst_subkey", 64'(subkey), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run_checked(KEY0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, K16_KNOWN, K1_KNOWN);

        // Asynchronous reset in the middle of a job.
        model_push(KEY0, 1'b0);
        key = KEY0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (subkey_valid && round == 4'd7) seen = 1'b1;
        end
        check("reach_round7", 64'(seen), 64'd1);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valid", 64'(subkey_valid), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_round", 64'(round), 64'd0);
        check("midrst_subkey", 64'(subkey), 64'd0);
        @(posedge clk);
        #1;
        check("midrst_held_valid", 64'(subkey_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_checked(KEY0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, K16_KNOWN, K1_KNOWN);

        run_checked(KEY0, 1'b0, 1'b1, 1'b0, 1'b0, 64'd0, K16_KNOWN, K1_KNOWN);

        run_checked(KEY0, 1'b0, 1'b0, 1'b1, 1'b1, {$urandom, $urandom}, K16_KNOWN, K1_KNOWN);
        wait_done("chain_done");
        @(posedge clk);
        #1;
        check("chain_queue_empty", 64'(exp_q.size()), 64'd0);

`ifdef DES_KS_ENC_EN
        run_checked(KEY0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, K1_KNOWN, K16_KNOWN);
`endif

        // Random keys, random hold, ignored start pulses and key changes while busy.
        for (int j = 0; j < 1000; j++) begin
            k = {$urandom, $urandom};
            enc = 1'b0;
`ifdef DES_KS_ENC_EN
            enc = 1'($urandom_range(0, 1));
`endif
            model_push(k, enc);
            key = k;
            drive_mode(enc);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            key = {$urandom, $urandom};
            seen = 1'b0;
            for (int c = 0; c < 200 && !seen; c++) begin
                @(negedge clk);
                start = 1'b0;
                hold = ($urandom_range(0, 3) == 0);
                if (done) begin
                    seen = 1'b1;
                end else if (busy && $urandom_range(0, 7) == 0) begin
                    start = 1'b1;
                    key = {$urandom, $urandom};
                end
            end
            start = 1'b0;
            hold = 1'b0;
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL rand_done_timeout actual=no_done required=done job=%0d", j);
            end
        end

        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
